// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: memory command encoding,
// arbiter state encoding and counter width.
package dmem_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] MEMCTL_IDLE  = 2'b00;
    localparam logic [1:0] MEMCTL_READ  = 2'b01;
    localparam logic [1:0] MEMCTL_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_C = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lat_timer.sv
// Loadable down-counter that tracks cycles remaining until read data is valid.
module dmem_lat_timer
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core MEM stage and a DMA port,
// with fixed read latency tracking and DMA starvation protection.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int DMA_STARVE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  core_mem_ctrl,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [1:0]  mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(DMA_STARVE);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             lat_zero;
    logic             core_valid;
    logic             core_read;
    logic             dma_win;
    logic             core_win;
    logic             lat_load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= STARVE_MAX) ? STARVE_MAX : v + 1'b1;
    endfunction

    assign core_valid = (core_mem_ctrl == MEMCTL_READ) || (core_mem_ctrl == MEMCTL_WRITE);
    assign core_read  = (core_mem_ctrl == MEMCTL_READ);
    assign dma_win    = (state == ST_IDLE) && dma_req &&
                        (!core_valid || (starve_cnt == STARVE_MAX));
    assign core_win   = (state == ST_IDLE) && core_valid && !dma_win;
    assign lat_load   = (core_win && core_read) || (dma_win && !dma_we);

    dmem_lat_timer u_lat_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (lat_load),
        .load_val (LAT_LOAD),
        .dec      (state != ST_IDLE),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dma_win) begin
                        starve_cnt <= '0;
                        if (!dma_we) state <= ST_WAIT_D;
                    end else if (core_win) begin
                        starve_cnt <= dma_req ? sat_inc(starve_cnt) : '0;
                        if (core_read) state <= ST_WAIT_C;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ST_WAIT_C: if (lat_zero) state <= ST_IDLE;
                ST_WAIT_D: if (lat_zero) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Issue and data-return signals are combinational and forced quiet in reset.
    always_comb begin
        mem_ctrl   = MEMCTL_IDLE;
        mem_addr   = '0;
        mem_wdata  = '0;
        core_stall = 1'b0;
        core_rdata = '0;
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = '0;
        if (reset_n) begin
            case (state)
                ST_IDLE: begin
                    if (dma_win) begin
                        mem_ctrl   = dma_we ? MEMCTL_WRITE : MEMCTL_READ;
                        mem_addr   = dma_addr;
                        mem_wdata  = dma_wdata;
                        dma_gnt    = 1'b1;
                        core_stall = core_valid;
                    end else if (core_win) begin
                        mem_ctrl   = core_mem_ctrl;
                        mem_addr   = core_addr;
                        mem_wdata  = core_wdata;
                        core_stall = core_read;
                    end
                end
                ST_WAIT_C: begin
                    if (lat_zero) core_rdata = mem_rdata;
                    else          core_stall = 1'b1;
                end
                ST_WAIT_D: begin
                    core_stall = core_valid;
                    if (lat_zero) begin
                        dma_rvalid = 1'b1;
                        dma_rdata  = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
